// File: rtl/pwm_fader_multi_if.sv
// ============================================================================
// Module  : pwm_fader_multi_if
// Brief   : Configuration write channel for the multi-channel PWM fader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_fader_multi_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    localparam int c_CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                wr_valid;
    logic [c_CHAN_W-1:0] wr_chan;
    logic [1:0]          wr_mode;
    logic [WIDTH-1:0]    wr_duty;
    logic                wr_ready;

    modport master (
        output wr_valid, wr_chan, wr_mode, wr_duty,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_chan, wr_mode, wr_duty,
        output wr_ready
    );
endinterface

`default_nettype wire

// File: rtl/pwm_fader_multi.sv
// ============================================================================
// Module  : pwm_fader_multi
// Brief   : Multi-channel PWM LED driver with OFF / STATIC / BREATHE / RAMP
//           modes, shared PWM counter and fade prescaler, optional phase
//           staggering of channel edges.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_fader_multi #(
    parameter int CHANNELS      = 4,
    parameter int WIDTH         = 8,
    parameter int FADE_DIV      = 400,
    parameter int PHASE_STAGGER = 1
) (
    input  wire                  i_Clk,
    input  wire                  i_Rst_L,
    pwm_fader_multi_if.slave     wr,
    output logic [CHANNELS-1:0]  o_LED,
    output logic                 o_Period_Start,
    output logic                 o_Fade_Tick
);
    localparam int c_CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_PRE_W      = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam int c_PHASE_STEP = (1 << WIDTH) / CHANNELS;

    localparam logic [1:0] c_MODE_OFF     = 2'd0;
    localparam logic [1:0] c_MODE_STATIC  = 2'd1;
    localparam logic [1:0] c_MODE_BREATHE = 2'd2;
    localparam logic [1:0] c_MODE_RAMP    = 2'd3;

    logic [WIDTH-1:0]    r_cnt_q,   w_cnt_d;
    logic [c_PRE_W-1:0]  r_presc_q, w_presc_d;
    logic [1:0]          r_mode_q [CHANNELS];
    logic [1:0]          w_mode_d [CHANNELS];
    logic [WIDTH-1:0]    r_tgt_q  [CHANNELS];
    logic [WIDTH-1:0]    w_tgt_d  [CHANNELS];
    logic [WIDTH-1:0]    r_duty_q [CHANNELS];
    logic [WIDTH-1:0]    w_duty_d [CHANNELS];
    logic [WIDTH-1:0]    w_pc     [CHANNELS];
    logic [CHANNELS-1:0] r_dir_q,   w_dir_d;
    logic [CHANNELS-1:0] r_led_q,   w_led_d;
    logic                r_ready_q;
    logic                r_ps_q;
    logic                r_ft_q;

    logic                w_boundary;
    logic                w_fade_step;
    logic                w_wr_accept;
    logic                w_chan_ok;

    // Shared PWM counter and fade prescaler; the prescaler only moves on period boundaries.
    always_comb begin
        w_boundary  = (r_cnt_q == '1);
        w_fade_step = w_boundary && (r_presc_q == c_PRE_W'(FADE_DIV - 1));
        w_cnt_d     = r_cnt_q + WIDTH'(1);
        w_presc_d   = r_presc_q;
        if (w_boundary) begin
            w_presc_d = w_fade_step ? '0 : r_presc_q + c_PRE_W'(1);
        end
        w_wr_accept = wr.wr_valid && r_ready_q;
        w_chan_ok   = (32'(wr.wr_chan) < CHANNELS);
    end

    // Per-channel duty update at the boundary (using pre-write mode/tgt), then write capture.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            w_mode_d[k] = r_mode_q[k];
            w_tgt_d[k]  = r_tgt_q[k];
            w_duty_d[k] = r_duty_q[k];
            w_dir_d[k]  = r_dir_q[k];

            if (w_boundary) begin
                case (r_mode_q[k])
                    c_MODE_OFF:    w_duty_d[k] = '0;
                    c_MODE_STATIC: w_duty_d[k] = r_tgt_q[k];
                    c_MODE_BREATHE: begin
                        if (w_fade_step) begin
                            if (!r_dir_q[k]) begin
                                if (r_duty_q[k] >= r_tgt_q[k]) begin
                                    // Peak reached: turn around, saturating at zero.
                                    w_duty_d[k] = (r_tgt_q[k] == '0) ? '0 : r_tgt_q[k] - WIDTH'(1);
                                    w_dir_d[k]  = 1'b1;
                                end else begin
                                    w_duty_d[k] = r_duty_q[k] + WIDTH'(1);
                                end
                            end else begin
                                if (r_duty_q[k] == '0) begin
                                    // Valley reached; a zero peak pins the channel dark.
                                    if (r_tgt_q[k] != '0) begin
                                        w_duty_d[k] = WIDTH'(1);
                                        w_dir_d[k]  = 1'b0;
                                    end
                                end else begin
                                    w_duty_d[k] = r_duty_q[k] - WIDTH'(1);
                                end
                            end
                        end
                    end
                    c_MODE_RAMP: begin
                        if (w_fade_step) begin
                            if (r_duty_q[k] < r_tgt_q[k]) begin
                                w_duty_d[k] = r_duty_q[k] + WIDTH'(1);
                            end else if (r_duty_q[k] > r_tgt_q[k]) begin
                                w_duty_d[k] = r_duty_q[k] - WIDTH'(1);
                            end
                        end
                    end
                    default: w_duty_d[k] = r_duty_q[k];
                endcase
            end

            if (w_wr_accept && w_chan_ok && (wr.wr_chan == c_CHAN_W'(k))) begin
                w_mode_d[k] = wr.wr_mode;
                w_tgt_d[k]  = wr.wr_duty;
                if (wr.wr_mode != r_mode_q[k]) begin
                    w_dir_d[k] = 1'b0;
                end
            end
        end
    end

    // PWM compare per channel against its (optionally phase-shifted) counter.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            w_pc[k]    = (PHASE_STAGGER != 0) ? r_cnt_q + WIDTH'(k * c_PHASE_STEP) : r_cnt_q;
            w_led_d[k] = (w_pc[k] < r_duty_q[k]);
        end
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_cnt_q   <= '0;
            r_presc_q <= '0;
            r_dir_q   <= '0;
            r_led_q   <= '0;
            r_ready_q <= 1'b0;
            r_ps_q    <= 1'b0;
            r_ft_q    <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_mode_q[k] <= c_MODE_OFF;
                r_tgt_q[k]  <= '0;
                r_duty_q[k] <= '0;
            end
        end else begin
            r_cnt_q   <= w_cnt_d;
            r_presc_q <= w_presc_d;
            r_dir_q   <= w_dir_d;
            r_led_q   <= w_led_d;
            r_ready_q <= 1'b1;
            r_ps_q    <= w_boundary;
            r_ft_q    <= w_fade_step;
            for (int k = 0; k < CHANNELS; k++) begin
                r_mode_q[k] <= w_mode_d[k];
                r_tgt_q[k]  <= w_tgt_d[k];
                r_duty_q[k] <= w_duty_d[k];
            end
        end
    end

    assign wr.wr_ready     = r_ready_q;
    assign o_LED           = r_led_q;
    assign o_Period_Start  = r_ps_q;
    assign o_Fade_Tick     = r_ft_q;

endmodule

`default_nettype wire
